// File: rtl/memory_arbiter_if.sv
// memory_arbiter_if
// Requester-side bundle for the SRAM arbiter. Groups the three request
// channels that share the external SRAM:
//   VGA : vgaReq/vgaAddr  -> vgaRdata/vgaAck        (read-only frame fetch)
//   A   : aReq/aWrite/aAddr/aWdata -> aRdata/aAck   (CPU data, read/write)
//   B   : bReq/bAddr      -> bRdata/bAck            (CPU fetch, read-only)
// Modports:
//   master : the requesters (drive requests, receive data/acks)
//   slave  : the arbiter    (receives requests, drives data/acks)
interface memory_arbiter_if;
  logic        vgaReq;
  logic [17:0] vgaAddr;
  logic [15:0] vgaRdata;
  logic        vgaAck;

  logic        aReq;
  logic        aWrite;
  logic [17:0] aAddr;
  logic [15:0] aWdata;
  logic [15:0] aRdata;
  logic        aAck;

  logic        bReq;
  logic [17:0] bAddr;
  logic [15:0] bRdata;
  logic        bAck;

  modport master (
    output vgaReq, vgaAddr, aReq, aWrite, aAddr, aWdata, bReq, bAddr,
    input  vgaRdata, vgaAck, aRdata, aAck, bRdata, bAck
  );

  modport slave (
    input  vgaReq, vgaAddr, aReq, aWrite, aAddr, aWdata, bReq, bAddr,
    output vgaRdata, vgaAck, aRdata, aAck, bRdata, bAck
  );
endinterface

// File: rtl/memory_arbiter.sv
// memory_arbiter
// Shares one 16-bit asynchronous SRAM between the VGA frame fetch and the
// two CPU ports (A data, B fetch). Owns strobe timing, the tri-state data
// bus and arbitration (VGA first, round-robin between A and B).
// Ports:
//   clk        : system clock
//   rst        : asynchronous, active-low reset
//   req_if     : requester bundle (slave side), see memory_arbiter_if
//   memDataBus : SRAM data bus (bidirectional)
//   memAddrBus : SRAM word address (registered)
//   memRead    : SRAM output enable, active-low (registered)
//   memWrite   : SRAM write enable, active-low (registered)
//   memEnable  : SRAM chip enable, active-low (registered)
//   busy       : high whenever the FSM is not IDLE
module memory_arbiter #(
  parameter int ACCESS_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  memory_arbiter_if.slave         req_if,
  inout  wire  [15:0]             memDataBus,
  output logic [17:0]             memAddrBus,
  output logic                    memRead,
  output logic                    memWrite,
  output logic                    memEnable,
  output logic                    busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [1:0] ID_VGA   = 2'd0;
  localparam logic [1:0] ID_A     = 2'd1;
  localparam logic [1:0] ID_B     = 2'd2;
  localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

  state_t      r_state, r_state_next;
  logic [3:0]  r_cnt, r_cnt_next;
  logic [1:0]  r_win, r_win_next;
  logic [17:0] r_addr, r_addr_next;
  logic        r_write, r_write_next;
  logic [15:0] r_wdata, r_wdata_next;
  logic        r_rr, r_rr_next;          // 0 = A preferred, 1 = B preferred
  logic        r_en_n, r_en_n_next;
  logic        r_rd_n, r_rd_n_next;
  logic        r_wr_n, r_wr_n_next;
  logic [17:0] r_pin_addr, r_pin_addr_next;
  logic        r_drive, r_drive_next;
  logic [15:0] r_vga_rdata, r_vga_rdata_next;
  logic [15:0] r_a_rdata, r_a_rdata_next;
  logic [15:0] r_b_rdata, r_b_rdata_next;
  logic        r_vga_ack, r_vga_ack_next;
  logic        r_a_ack, r_a_ack_next;
  logic        r_b_ack, r_b_ack_next;

  always_comb begin
    r_state_next     = r_state;
    r_cnt_next       = r_cnt;
    r_win_next       = r_win;
    r_addr_next      = r_addr;
    r_write_next     = r_write;
    r_wdata_next     = r_wdata;
    r_rr_next        = r_rr;
    r_en_n_next      = r_en_n;
    r_rd_n_next      = r_rd_n;
    r_wr_n_next      = r_wr_n;
    r_pin_addr_next  = r_pin_addr;
    r_drive_next     = r_drive;
    r_vga_rdata_next = r_vga_rdata;
    r_a_rdata_next   = r_a_rdata;
    r_b_rdata_next   = r_b_rdata;
    // Acks are single-cycle pulses: only the ACCESS->DONE edge sets one.
    r_vga_ack_next   = 1'b0;
    r_a_ack_next     = 1'b0;
    r_b_ack_next     = 1'b0;

    case (r_state)
      IDLE: begin
        if (req_if.vgaReq || req_if.aReq || req_if.bReq) begin
          if (req_if.vgaReq) begin
            r_win_next   = ID_VGA;
            r_addr_next  = req_if.vgaAddr;
            r_write_next = 1'b0;
          end else if (req_if.aReq && (!req_if.bReq || !r_rr)) begin
            r_win_next   = ID_A;
            r_addr_next  = req_if.aAddr;
            r_write_next = req_if.aWrite;
            r_wdata_next = req_if.aWdata;
            r_rr_next    = 1'b1;
          end else begin
            r_win_next   = ID_B;
            r_addr_next  = req_if.bAddr;
            r_write_next = 1'b0;
            r_rr_next    = 1'b0;
          end
          r_cnt_next      = CNT_LOAD;
          r_state_next    = ACCESS;
          // Pins are registered, so they are set up on the grant edge to be
          // active for the first ACCESS cycle.
          r_en_n_next     = 1'b0;
          r_rd_n_next     = r_write_next;
          r_wr_n_next     = !r_write_next;
          r_pin_addr_next = r_addr_next;
          r_drive_next    = r_write_next;
        end
      end

      ACCESS: begin
        if (r_cnt == 4'd0) begin
          r_state_next = DONE;
          r_en_n_next  = 1'b1;
          r_rd_n_next  = 1'b1;
          r_wr_n_next  = 1'b1;
          // r_drive stays set through DONE for write data hold time.
          case (r_win)
            ID_VGA: begin
              r_vga_ack_next   = 1'b1;
              r_vga_rdata_next = memDataBus;
            end
            ID_A: begin
              r_a_ack_next = 1'b1;
              if (!r_write) r_a_rdata_next = memDataBus;
            end
            default: begin
              r_b_ack_next   = 1'b1;
              r_b_rdata_next = memDataBus;
            end
          endcase
        end else begin
          r_cnt_next = r_cnt - 4'd1;
        end
      end

      DONE: begin
        r_state_next = IDLE;
        r_drive_next = 1'b0;
      end

      default: begin
        r_state_next = IDLE;
        r_drive_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_cnt       <= 4'd0;
      r_win       <= ID_VGA;
      r_addr      <= 18'd0;
      r_write     <= 1'b0;
      r_wdata     <= 16'd0;
      r_rr        <= 1'b0;
      r_en_n      <= 1'b1;
      r_rd_n      <= 1'b1;
      r_wr_n      <= 1'b1;
      r_pin_addr  <= 18'd0;
      r_drive     <= 1'b0;
      r_vga_rdata <= 16'd0;
      r_a_rdata   <= 16'd0;
      r_b_rdata   <= 16'd0;
      r_vga_ack   <= 1'b0;
      r_a_ack     <= 1'b0;
      r_b_ack     <= 1'b0;
    end else begin
      r_state     <= r_state_next;
      r_cnt       <= r_cnt_next;
      r_win       <= r_win_next;
      r_addr      <= r_addr_next;
      r_write     <= r_write_next;
      r_wdata     <= r_wdata_next;
      r_rr        <= r_rr_next;
      r_en_n      <= r_en_n_next;
      r_rd_n      <= r_rd_n_next;
      r_wr_n      <= r_wr_n_next;
      r_pin_addr  <= r_pin_addr_next;
      r_drive     <= r_drive_next;
      r_vga_rdata <= r_vga_rdata_next;
      r_a_rdata   <= r_a_rdata_next;
      r_b_rdata   <= r_b_rdata_next;
      r_vga_ack   <= r_vga_ack_next;
      r_a_ack     <= r_a_ack_next;
      r_b_ack     <= r_b_ack_next;
    end
  end

  assign memDataBus      = r_drive ? r_wdata : 16'hzzzz;
  assign memAddrBus      = r_pin_addr;
  assign memRead         = r_rd_n;
  assign memWrite        = r_wr_n;
  assign memEnable       = r_en_n;
  assign busy            = (r_state != IDLE);

  assign req_if.vgaRdata = r_vga_rdata;
  assign req_if.vgaAck   = r_vga_ack;
  assign req_if.aRdata   = r_a_rdata;
  assign req_if.aAck     = r_a_ack;
  assign req_if.bRdata   = r_b_rdata;
  assign req_if.bAck     = r_b_ack;

endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter
// Directed bench for memory_arbiter with ACCESS_CYCLES = 2. A 16-word SRAM
// model (indexed by address[3:0]) answers reads while OE and CE are low and
// stores writes while WE and CE are low. A separate probe driver puts 0x5A5A
// on the bus; reading 0x5A5A back shows the arbiter has released the bus.
module tb_memory_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  memory_arbiter_if bus_if();

  wire  [15:0] memDataBus;
  logic [17:0] memAddrBus;
  logic        memRead;
  logic        memWrite;
  logic        memEnable;
  logic        busy;

  memory_arbiter #(.ACCESS_CYCLES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_if     (bus_if),
    .memDataBus (memDataBus),
    .memAddrBus (memAddrBus),
    .memRead    (memRead),
    .memWrite   (memWrite),
    .memEnable  (memEnable),
    .busy       (busy)
  );

  // SRAM model plus backdoor loader
  logic [15:0] sram_mem [0:15];
  logic        bk_we   = 1'b0;
  logic [3:0]  bk_addr = 4'd0;
  logic [15:0] bk_data = 16'd0;
  logic        probe_en = 1'b0;
  wire         sram_oe = !memEnable && !memRead;

  assign memDataBus = sram_oe  ? sram_mem[memAddrBus[3:0]] : 16'hzzzz;
  assign memDataBus = probe_en ? 16'h5A5A : 16'hzzzz;

  always @(posedge clk) begin
    if (bk_we) sram_mem[bk_addr] <= bk_data;
    else if (!memEnable && !memWrite) sram_mem[memAddrBus[3:0]] <= memDataBus;
  end

  int n_cmp  = 0;
  int n_fail = 0;
  int t_vga, t_a, t_b, n_gr, saw_ack;
  int order [0:3];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic load(input logic [3:0] a, input logic [15:0] d);
    @(negedge clk);
    bk_we = 1'b1; bk_addr = a; bk_data = d;
    @(negedge clk);
    bk_we = 1'b0;
    $display("load sram[%h] = %h", a, d);
  endtask

  task automatic check_bus_released(input string tag);
    probe_en = 1'b1;
    #1;
    check(tag, 32'(memDataBus), 32'h5A5A);
    probe_en = 1'b0;
  endtask

  initial begin
    bus_if.vgaReq = 1'b0; bus_if.vgaAddr = '0;
    bus_if.aReq = 1'b0; bus_if.aWrite = 1'b0; bus_if.aAddr = '0; bus_if.aWdata = '0;
    bus_if.bReq = 1'b0; bus_if.bAddr = '0;

    // ---- reset state ----
    cyc(); cyc();
    check("rst_en",    32'(memEnable), 32'h1);
    check("rst_rd",    32'(memRead),   32'h1);
    check("rst_wr",    32'(memWrite),  32'h1);
    check("rst_addr",  32'(memAddrBus), 32'h0);
    check("rst_busy",  32'(busy), 32'h0);
    check("rst_acks",  32'({bus_if.vgaAck, bus_if.aAck, bus_if.bAck}), 32'h0);
    check_bus_released("rst_bus_z");
    rst = 1'b1;
    $display("reset released");
    load(4'hF, 16'h1234);
    load(4'h5, 16'hCAFE);

    // ---- A write 0x00123 <= 0xBEEF ----
    cyc();
    bus_if.aReq = 1'b1; bus_if.aWrite = 1'b1; bus_if.aAddr = 18'h00123; bus_if.aWdata = 16'hBEEF;
    cyc();
    check("aw_c1_en",   32'(memEnable), 32'h0);
    check("aw_c1_wr",   32'(memWrite),  32'h0);
    check("aw_c1_rd",   32'(memRead),   32'h1);
    check("aw_c1_addr", 32'(memAddrBus), 32'h00123);
    check("aw_c1_bus",  32'(memDataBus), 32'hBEEF);
    check("aw_c1_busy", 32'(busy), 32'h1);
    cyc();
    check("aw_c2_wr",   32'(memWrite),  32'h0);
    check("aw_c2_ack",  32'(bus_if.aAck), 32'h0);
    cyc();
    check("aw_c3_ack",  32'(bus_if.aAck), 32'h1);
    check("aw_c3_bus",  32'(memDataBus), 32'hBEEF);
    check("aw_c3_str",  32'({memEnable, memRead, memWrite}), 32'h7);
    check("aw_c3_ardata", 32'(bus_if.aRdata), 32'h0);
    bus_if.aReq = 1'b0;
    cyc();
    check("aw_c4_ack",  32'(bus_if.aAck), 32'h0);
    check("aw_c4_busy", 32'(busy), 32'h0);
    check_bus_released("aw_c4_bus_z");
    $display("A write 00123 <= BEEF done");

    // ---- B read 0x3FFFF -> 0x1234 ----
    bus_if.bReq = 1'b1; bus_if.bAddr = 18'h3FFFF;
    cyc();
    check("br_c1_rd",   32'(memRead), 32'h0);
    check("br_c1_wr",   32'(memWrite), 32'h1);
    check("br_c1_addr", 32'(memAddrBus), 32'h3FFFF);
    cyc();
    check("br_c2_rd",   32'(memRead), 32'h0);
    cyc();
    check("br_c3_ack",  32'(bus_if.bAck), 32'h1);
    check("br_c3_data", 32'(bus_if.bRdata), 32'h1234);
    check("br_c3_rd",   32'(memRead), 32'h1);
    bus_if.bReq = 1'b0;
    cyc();
    check("br_c4_ack",  32'(bus_if.bAck), 32'h0);
    check("br_c4_hold", 32'(bus_if.bRdata), 32'h1234);
    $display("B read 3FFFF -> %h", bus_if.bRdata);
    load(4'hF, 16'h4321);

    // ---- simultaneous VGA/A/B ----
    cyc();
    bus_if.vgaReq = 1'b1; bus_if.vgaAddr = 18'h00005;
    bus_if.aReq = 1'b1; bus_if.aWrite = 1'b0; bus_if.aAddr = 18'h00123;
    bus_if.bReq = 1'b1; bus_if.bAddr = 18'h3FFFF;
    t_vga = -1; t_a = -1; t_b = -1;
    for (int c = 1; c <= 16; c++) begin
      cyc();
      if (bus_if.vgaAck) begin t_vga = c; bus_if.vgaReq = 1'b0; end
      if (bus_if.aAck)   begin t_a = c;   bus_if.aReq = 1'b0; end
      if (bus_if.bAck)   begin t_b = c;   bus_if.bReq = 1'b0; end
    end
    bus_if.vgaReq = 1'b0; bus_if.aReq = 1'b0; bus_if.bReq = 1'b0;
    check("sim_vga_cyc", 32'(t_vga), 32'd3);
    check("sim_a_cyc",   32'(t_a),   32'd7);
    check("sim_b_cyc",   32'(t_b),   32'd11);
    check("sim_vga_data", 32'(bus_if.vgaRdata), 32'hCAFE);
    check("sim_a_data",   32'(bus_if.aRdata),   32'hBEEF);
    check("sim_b_data",   32'(bus_if.bRdata),   32'h4321);
    $display("simultaneous acks at %0d/%0d/%0d", t_vga, t_a, t_b);

    // ---- round-robin A/B held ----
    bus_if.aReq = 1'b1; bus_if.aWrite = 1'b0; bus_if.aAddr = 18'h00123;
    bus_if.bReq = 1'b1; bus_if.bAddr = 18'h3FFFF;
    n_gr = 0;
    for (int i = 0; i < 4; i++) order[i] = 0;
    for (int c = 1; c <= 40 && n_gr < 4; c++) begin
      cyc();
      if (bus_if.aAck && n_gr < 4) begin order[n_gr] = 1; n_gr++; end
      if (bus_if.bAck && n_gr < 4) begin order[n_gr] = 2; n_gr++; end
    end
    bus_if.aReq = 1'b0; bus_if.bReq = 1'b0;
    check("rr_count", 32'(n_gr), 32'd4);
    check("rr_g0", 32'(order[0]), 32'd1);
    check("rr_g1", 32'(order[1]), 32'd2);
    check("rr_g2", 32'(order[2]), 32'd1);
    check("rr_g3", 32'(order[3]), 32'd2);
    $display("round-robin order %0d %0d %0d %0d", order[0], order[1], order[2], order[3]);

    // ---- reset during A write ----
    cyc();
    check("rm_idle", 32'(busy), 32'h0);
    bus_if.aReq = 1'b1; bus_if.aWrite = 1'b1; bus_if.aAddr = 18'h00007; bus_if.aWdata = 16'h7777;
    cyc();
    check("rm_c1_wr", 32'(memWrite), 32'h0);
    cyc();
    rst = 1'b0;
    #1;
    check("rm_async_str",  32'({memEnable, memRead, memWrite}), 32'h7);
    check("rm_async_busy", 32'(busy), 32'h0);
    check_bus_released("rm_async_bus_z");
    saw_ack = 0;
    for (int c = 0; c < 3; c++) begin
      cyc();
      if (bus_if.aAck) saw_ack++;
    end
    rst = 1'b1;
    check("rm_no_ack",  32'(saw_ack), 32'd0);
    check("rm_addr0",   32'(memAddrBus), 32'h0);
    check("rm_rdata0",  32'({bus_if.vgaRdata, bus_if.aRdata}), 32'h0);
    check("rm_brdata0", 32'(bus_if.bRdata), 32'h0);
    cyc();
    check("rm_re_wr",   32'(memWrite), 32'h0);
    check("rm_re_addr", 32'(memAddrBus), 32'h00007);
    cyc();
    cyc();
    check("rm_re_ack",  32'(bus_if.aAck), 32'h1);
    bus_if.aReq = 1'b0;
    cyc();
    check("rm_re_idle", 32'(busy), 32'h0);
    check("rm_re_mem",  32'(sram_mem[7]), 32'h7777);
    $display("reissued write after reset done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
